// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM states, exception causes, funct3 codes.
// Imported by lsu_align and lsu_unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB,
        S_DRAIN
    } lsu_state_e;

    localparam logic [3:0] CAUSE_LD_MISAL = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISAL = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;
    localparam logic [2:0] F3_SD = 3'd3;

    // Illegal funct3 is reported with the misalign cause of its direction.
    function automatic logic [3:0] exc_cause(input logic st, input logic misal);
        if (misal) return st ? CAUSE_ST_MISAL : CAUSE_LD_MISAL;
        return st ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data shift, misalign/illegal check,
// load byte extraction with sign/zero extension. Ports: st_* store side, ld_* load side.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OW   = $clog2(NB)
) (
    input  logic [OW-1:0]   st_off_i,
    input  logic [2:0]      st_f3_i,
    input  logic            st_is_store_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [NB-1:0]   st_strobe_o,
    output logic [XLEN-1:0] st_wdata_o,
    output logic            st_exc_o,
    input  logic [OW-1:0]   ld_off_i,
    input  logic [2:0]      ld_f3_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    localparam bit IS64 = (XLEN == 64);

    logic [NB-1:0]   bmask;
    logic [OW-1:0]   amask;
    logic            illegal;
    logic [XLEN-1:0] sh;

    always_comb begin
        bmask = NB'(8'h01);
        amask = '0;
        case (st_f3_i[1:0])
            2'd0: begin bmask = NB'(8'h01); amask = OW'(3'd0); end
            2'd1: begin bmask = NB'(8'h03); amask = OW'(3'd1); end
            2'd2: begin bmask = NB'(8'h0F); amask = OW'(3'd3); end
            2'd3: begin bmask = NB'(8'hFF); amask = OW'(3'd7); end
        endcase
    end

    always_comb begin
        if (st_is_store_i)
            illegal = st_f3_i[2] | (!IS64 & (st_f3_i[1:0] == 2'd3));
        else
            illegal = (st_f3_i == 3'd7)
                    | (!IS64 & ((st_f3_i == F3_LD) | (st_f3_i == F3_LWU)));
    end

    assign st_exc_o    = illegal | (|(st_off_i & amask));
    assign st_strobe_o = bmask << st_off_i;
    assign st_wdata_o  = st_data_i << {st_off_i, 3'b000};

    assign sh = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = sh;
        unique case (ld_f3_i)
            F3_LB:   ld_data_o = XLEN'($signed(sh[7:0]));
            F3_LH:   ld_data_o = XLEN'($signed(sh[15:0]));
            F3_LW:   ld_data_o = XLEN'($signed(sh[31:0]));
            F3_LBU:  ld_data_o = XLEN'(sh[7:0]);
            F3_LHU:  ld_data_o = XLEN'(sh[15:0]);
            F3_LWU:  ld_data_o = XLEN'(sh[31:0]);
            default: ld_data_o = sh;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: issue -> bus request -> response wait -> writeback, one op in flight.
// Ports: issue_* from register manager, mem_* bus, wb_* writeback; flush drops the op.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_v,
    output logic              issue_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   imm,
    input  logic [4:0]        rd_i,
    output logic              mem_req_v,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_adr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_strobe,
    input  logic              mem_resp_v,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err,
    output logic              wb_v,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_exc,
    output logic [3:0]        wb_cause
);

    localparam int          NB      = XLEN / 8;
    localparam int          OW      = $clog2(NB);
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NB-1:0]   strb_q, strb_d;
    logic [2:0]      f3_q, f3_d;
    logic            st_q, st_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_exc_q, wb_exc_d;
    logic [3:0]      wb_cause_q, wb_cause_d;

    logic [XLEN-1:0] adr_c, al_wdata, al_ld;
    logic [NB-1:0]   al_strb;
    logic            al_exc, accept, timeout;

    assign adr_c       = rs1 + imm;
    assign issue_ready = (state_q == S_IDLE) & !flush & !rst;
    assign accept      = issue_v & issue_ready;
    // cnt_q counts completed WAIT/DRAIN cycles; this is the last allowed one.
    assign timeout     = TO_EN & (cnt_q == TO_LAST);

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_off_i      (adr_c[OW-1:0]),
        .st_f3_i       (funct3),
        .st_is_store_i (is_store),
        .st_data_i     (rs2),
        .st_strobe_o   (al_strb),
        .st_wdata_o    (al_wdata),
        .st_exc_o      (al_exc),
        .ld_off_i      (adr_q[OW-1:0]),
        .ld_f3_i       (f3_q),
        .ld_rdata_i    (mem_rdata),
        .ld_data_o     (al_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            f3_q       <= '0;
            st_q       <= 1'b0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_exc_q   <= 1'b0;
            wb_cause_q <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            f3_q       <= f3_d;
            st_q       <= st_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_exc_q   <= wb_exc_d;
            wb_cause_q <= wb_cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        f3_d       = f3_q;
        st_d       = st_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_exc_d   = wb_exc_q;
        wb_cause_d = wb_cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    adr_d   = adr_c;
                    wdata_d = al_wdata;
                    strb_d  = al_strb;
                    f3_d    = funct3;
                    st_d    = is_store;
                    rd_d    = rd_i;
                    cnt_d   = '0;
                    if (al_exc) begin
                        state_d    = S_WB;
                        wb_exc_d   = 1'b1;
                        wb_cause_d = exc_cause(is_store, 1'b1);
                        wb_data_d  = adr_c;
                        wb_rd_d    = '0;
                    end else begin
                        state_d    = S_REQ;
                        wb_exc_d   = 1'b0;
                        wb_cause_d = '0;
                    end
                end
            end
            S_REQ: begin
                if (flush)              state_d = S_IDLE;
                else if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_resp_v) begin
                    // Flush racing the response: nothing left to drain.
                    state_d = flush ? S_IDLE : S_WB;
                    if (mem_err) begin
                        wb_exc_d   = 1'b1;
                        wb_cause_d = exc_cause(st_q, 1'b0);
                        wb_data_d  = adr_q;
                        wb_rd_d    = '0;
                    end else begin
                        wb_data_d = st_q ? '0 : al_ld;
                        wb_rd_d   = st_q ? 5'd0 : rd_q;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else if (timeout) begin
                    state_d    = S_WB;
                    wb_exc_d   = 1'b1;
                    wb_cause_d = exc_cause(st_q, 1'b0);
                    wb_data_d  = adr_q;
                    wb_rd_d    = '0;
                end
            end
            S_WB: begin
                if (flush || wb_ready) state_d = S_IDLE;
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_resp_v || timeout) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req_v  = (state_q == S_REQ) & !flush;
    assign mem_we     = st_q;
    assign mem_adr    = {adr_q[XLEN-1:OW], {OW{1'b0}}};
    assign mem_wdata  = wdata_q;
    assign mem_strobe = strb_q;

    assign wb_v     = (state_q == S_WB) & !flush;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_exc   = wb_exc_q;
    assign wb_cause = wb_cause_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit (XLEN=32): expected writebacks are queued
// at issue and popped when the unit produces its writeback.
module tb_lsu_unit;

    typedef struct packed {
        logic        iss_rdy;
        logic        req;
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] lat;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, flush, issue_v, issue_ready, is_store;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd_i;
    logic        mem_req_v, mem_req_ready, mem_we;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strobe;
    logic        mem_resp_v, mem_err;
    logic        wb_v, wb_ready, wb_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  wb_cause;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    lsu_unit #(.XLEN(32), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_v(issue_v), .issue_ready(issue_ready),
        .is_store(is_store), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .imm(imm), .rd_i(rd_i),
        .mem_req_v(mem_req_v), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_strobe(mem_strobe),
        .mem_resp_v(mem_resp_v), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .wb_v(wb_v), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_exc(wb_exc), .wb_cause(wb_cause)
    );

    function automatic logic [31:0] model_ld(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            3'd0: return {{24{s[7]}}, s[7:0]};
            3'd1: return {{16{s[15]}}, s[15:0]};
            3'd4: return {24'h0, s[7:0]};
            3'd5: return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Drives one issue, acts as bus, returns what the unit showed.
    // Returns at the negedge where wb_v is first seen (or after max_cyc).
    task automatic run_access(input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] im,
                              input logic [31:0] d, input logic [4:0] rd,
                              input int rdly, input logic [31:0] rdat,
                              input logic err, input int max_cyc,
                              output obs_t o);
        int c_r;
        o = '0;
        c_r = -1;
        @(negedge clk);
        issue_v = 1'b1; is_store = st; funct3 = f3;
        rs1 = a; imm = im; rs2 = d; rd_i = rd;
        o.iss_rdy = issue_ready;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            issue_v = 1'b0;
            mem_req_ready = 1'b0;
            mem_resp_v = 1'b0;
            mem_err = 1'b0;
            if (wb_v) begin
                o.wb = 1'b1; o.lat = c; o.rd = wb_rd;
                o.data = wb_data; o.exc = wb_exc; o.cause = wb_cause;
                break;
            end
            if (mem_req_v && !o.req) begin
                o.req = 1'b1; o.adr = mem_adr; o.we = mem_we;
                o.wdata = mem_wdata; o.strb = mem_strobe;
                mem_req_ready = 1'b1;
                c_r = c;
            end
            if (c_r >= 0 && rdly >= 0 && c == c_r + 1 + rdly) begin
                mem_resp_v = 1'b1; mem_rdata = rdat; mem_err = err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", issue_ready); end
        n_tests++;
        if ({mem_req_v, wb_v, wb_exc} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b want 000", {mem_req_v, wb_v, wb_exc}); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", issue_ready); end
        n_tests++;
        if ({mem_adr, mem_strobe, wb_data, wb_cause} !== '0) begin n_fail++; $display("FAIL rst_outputs: adr %h strb %h data %h cause %h want 0", mem_adr, mem_strobe, wb_data, wb_cause); end
    endtask

    task automatic test_lw();
        obs_t o, e;
        e = '0; e.adr = 32'h104; e.strb = 4'hF; e.rd = 5'd7; e.data = 32'hDEADBEEF; e.lat = 32'd3;
        sb.push_back(e);
        run_access(1'b0, 3'd2, 32'h100, 32'h4, 32'h0, 5'd7, 0, 32'hDEADBEEF, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (!o.req || o.adr !== e.adr || o.strb !== e.strb || o.we !== 1'b0) begin n_fail++; $display("FAIL lw_req: req %b adr %h strb %b we %b want adr %h strb %b we 0", o.req, o.adr, o.strb, o.we, e.adr, e.strb); end
        n_tests++;
        if (!o.wb || o.data !== e.data || o.rd !== e.rd || o.exc !== 1'b0) begin n_fail++; $display("FAIL lw_wb: wb %b data %h rd %0d exc %b want data %h rd %0d", o.wb, o.data, o.rd, o.exc, e.data, e.rd); end
        n_tests++;
        if (o.lat !== e.lat) begin n_fail++; $display("FAIL lw_latency: got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_lb_lbu();
        obs_t o, e;
        e = '0; e.data = 32'hFFFFFF80; sb.push_back(e);
        run_access(1'b0, 3'd0, 32'h100, 32'h3, 32'h0, 5'd3, 0, 32'h80123456, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (o.data !== e.data || o.strb !== 4'b1000 || o.adr !== 32'h100) begin n_fail++; $display("FAIL lb: data %h strb %b adr %h want %h 1000 00000100", o.data, o.strb, o.adr, e.data); end
        e = '0; e.data = 32'h00000080; sb.push_back(e);
        run_access(1'b0, 3'd4, 32'h100, 32'h3, 32'h0, 5'd3, 0, 32'h80123456, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (o.data !== e.data) begin n_fail++; $display("FAIL lbu: got %h want %h", o.data, e.data); end
        e = '0; e.data = 32'hFFFF8001; sb.push_back(e);
        run_access(1'b0, 3'd1, 32'h104, 32'hFFFFFFFE, 32'h0, 5'd4, 1, 32'h80015555, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (o.data !== e.data || o.adr !== 32'h100 || o.strb !== 4'b1100) begin n_fail++; $display("FAIL lh_negimm: data %h adr %h strb %b want %h 00000100 1100", o.data, o.adr, o.strb, e.data); end
    endtask

    task automatic test_sh();
        obs_t o, e;
        e = '0; e.strb = 4'b1100; e.wdata = 32'h12340000; e.we = 1'b1; e.rd = 5'd0;
        sb.push_back(e);
        run_access(1'b1, 3'd1, 32'h100, 32'h2, 32'hABCD1234, 5'd9, 0, 32'h0, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (o.strb !== e.strb || o.wdata !== e.wdata || o.we !== e.we) begin n_fail++; $display("FAIL sh_bus: strb %b wdata %h we %b want %b %h %b", o.strb, o.wdata, o.we, e.strb, e.wdata, e.we); end
        n_tests++;
        if (!o.wb || o.rd !== e.rd || o.exc !== 1'b0) begin n_fail++; $display("FAIL sh_wb: wb %b rd %0d exc %b want 1 0 0", o.wb, o.rd, o.exc); end
    endtask

    task automatic test_misalign();
        obs_t o, e;
        e = '0; e.exc = 1'b1; e.cause = 4'd4; e.data = 32'h102; e.lat = 32'd1;
        sb.push_back(e);
        run_access(1'b0, 3'd2, 32'h100, 32'h2, 32'h0, 5'd5, -1, 32'h0, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (o.req !== 1'b0) begin n_fail++; $display("FAIL lw_mis_noreq: got %b want 0", o.req); end
        n_tests++;
        if (o.exc !== e.exc || o.cause !== e.cause || o.data !== e.data || o.rd !== 5'd0 || o.lat !== e.lat) begin n_fail++; $display("FAIL lw_mis_wb: exc %b cause %0d data %h rd %0d lat %0d want 1 4 102 0 1", o.exc, o.cause, o.data, o.rd, o.lat); end
        e = '0; e.exc = 1'b1; e.cause = 4'd6; e.data = 32'h101;
        sb.push_back(e);
        run_access(1'b1, 3'd1, 32'h100, 32'h1, 32'h0, 5'd5, -1, 32'h0, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (o.req !== 1'b0 || o.exc !== e.exc || o.cause !== e.cause || o.data !== e.data) begin n_fail++; $display("FAIL sh_mis: req %b exc %b cause %0d data %h want 0 1 6 101", o.req, o.exc, o.cause, o.data); end
        e = '0; e.exc = 1'b1; e.cause = 4'd4; e.data = 32'h200;
        sb.push_back(e);
        run_access(1'b0, 3'd3, 32'h200, 32'h0, 32'h0, 5'd5, -1, 32'h0, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (o.req !== 1'b0 || o.exc !== e.exc || o.cause !== e.cause || o.data !== e.data) begin n_fail++; $display("FAIL ld_illegal: req %b exc %b cause %0d data %h want 0 1 4 200", o.req, o.exc, o.cause, o.data); end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        e = '0; e.exc = 1'b1; e.cause = 4'd5; e.data = 32'h300; e.lat = 32'd257;
        sb.push_back(e);
        run_access(1'b0, 3'd2, 32'h300, 32'h0, 32'h0, 5'd6, -1, 32'h0, 1'b0, 300, o);
        e = sb.pop_front();
        n_tests++;
        if (!o.wb || o.exc !== e.exc || o.cause !== e.cause || o.data !== e.data) begin n_fail++; $display("FAIL timeout_wb: wb %b exc %b cause %0d data %h want 1 1 5 300", o.wb, o.exc, o.cause, o.data); end
        n_tests++;
        if (o.lat !== e.lat) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_st_fault();
        obs_t o, e;
        e = '0; e.exc = 1'b1; e.cause = 4'd7; e.data = 32'h208;
        sb.push_back(e);
        run_access(1'b1, 3'd2, 32'h200, 32'h8, 32'h55AA55AA, 5'd8, 1, 32'h0, 1'b1, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (!o.wb || o.exc !== e.exc || o.cause !== e.cause || o.data !== e.data || o.rd !== 5'd0) begin n_fail++; $display("FAIL sw_err: wb %b exc %b cause %0d data %h rd %0d want 1 1 7 208 0", o.wb, o.exc, o.cause, o.data, o.rd); end
    endtask

    task automatic test_flush_drain();
        logic seen_wb, seen_rdy;
        seen_wb = 1'b0; seen_rdy = 1'b0;
        @(negedge clk);
        issue_v = 1'b1; is_store = 1'b0; funct3 = 3'd2;
        rs1 = 32'h400; imm = 32'h0; rd_i = 5'd10;
        @(negedge clk);
        issue_v = 1'b0;
        n_tests++;
        if (mem_req_v !== 1'b1) begin n_fail++; $display("FAIL drain_req: got %b want 1", mem_req_v); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        flush = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            flush = 1'b0;
            seen_wb |= wb_v;
            seen_rdy |= issue_ready;
        end
        mem_resp_v = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_resp_v = 1'b0;
        seen_wb |= wb_v;
        n_tests++;
        if (seen_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_early_ready: got %b want 0", seen_rdy); end
        n_tests++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_after_resp: got %b want 1", issue_ready); end
        @(negedge clk);
        mem_resp_v = 1'b1;
        @(negedge clk);
        mem_resp_v = 1'b0;
        seen_wb |= wb_v;
        n_tests++;
        if (seen_wb !== 1'b0 || issue_ready !== 1'b1 || mem_req_v !== 1'b0) begin n_fail++; $display("FAIL drain_quiet: wb %b ready %b req %b want 0 1 0", seen_wb, issue_ready, mem_req_v); end
    endtask

    task automatic test_flush_issue();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        issue_v = 1'b1; flush = 1'b1; is_store = 1'b0; funct3 = 3'd2;
        rs1 = 32'h500; imm = 32'h0; rd_i = 5'd2;
        #1;
        n_tests++;
        if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_issue_ready: got %b want 0", issue_ready); end
        @(negedge clk);
        issue_v = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            seen |= mem_req_v | wb_v;
            @(negedge clk);
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_issue_dropped: activity %b want 0", seen); end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        issue_v = 1'b1; is_store = 1'b1; funct3 = 3'd2;
        rs1 = 32'h600; imm = 32'h0; rs2 = 32'h1; rd_i = 5'd0;
        @(negedge clk);
        issue_v = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_req_v !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b want 0", mem_req_v); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", issue_ready); end
    endtask

    task automatic test_wb_hold();
        obs_t o, e;
        logic bad;
        bad = 1'b0;
        wb_ready = 1'b0;
        e = '0; e.data = 32'hFFFFFF80; e.rd = 5'd12;
        sb.push_back(e);
        run_access(1'b0, 3'd0, 32'h700, 32'h3, 32'h0, 5'd12, 2, 32'h80000000, 1'b0, 20, o);
        e = sb.pop_front();
        n_tests++;
        if (!o.wb || o.data !== e.data || o.rd !== e.rd) begin n_fail++; $display("FAIL hold_first: wb %b data %h rd %0d want 1 %h %0d", o.wb, o.data, o.rd, e.data, e.rd); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wb_v !== 1'b1 || wb_data !== e.data || wb_rd !== e.rd) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL hold_stable: wb_v %b data %h rd %0d want 1 %h %0d", wb_v, wb_data, wb_rd, e.data, e.rd); end
        wb_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (wb_v !== 1'b0 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: wb_v %b ready %b want 0 1", wb_v, issue_ready); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [2:0]  f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] a, im, w;
        int          dly;
        for (int i = 0; i < 8; i++) begin
            f3  = f3s[$urandom_range(0, 4)];
            off = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'd1) off[0] = 1'b0;
            if (f3[1:0] == 2'd2) off = 2'd0;
            im  = 32'($urandom_range(0, 255));
            a   = 32'h1000 + {30'h0, off} - im;
            w   = $urandom;
            dly = $urandom_range(0, 3);
            e = '0; e.iss_rdy = 1'b1; e.data = model_ld(f3, off, w);
            e.rd = 5'(i + 1); e.lat = 32'(3 + dly);
            sb.push_back(e);
            run_access(1'b0, f3, a, im, 32'h0, 5'(i + 1), dly, w, 1'b0, 20, o);
            e = sb.pop_front();
            n_tests++;
            if (o.iss_rdy !== 1'b1 || o.data !== e.data || o.rd !== e.rd || o.lat !== e.lat) begin n_fail++; $display("FAIL b2b_%0d: rdy %b data %h rd %0d lat %0d want 1 %h %0d %0d", i, o.iss_rdy, o.data, o.rd, o.lat, e.data, e.rd, e.lat); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_v = 1'b0; is_store = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0; imm = '0; rd_i = '0;
        mem_req_ready = 1'b0; mem_resp_v = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        wb_ready = 1'b1;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misalign();
        test_timeout();
        test_st_fault();
        test_flush_drain();
        test_flush_issue();
        test_rst_mid();
        test_wb_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
